// File: rtl/osd_spi_host.sv
// Single-byte SPI master (SCK idle high, shift on falling SCK, sample on rising SCK, MSB first).
// A byte-level start/done handshake faces local logic; cs_hold lets several bytes share one frame.
module osd_spi_host #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_IDLE     = 2
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       start,
    input  logic       cs_hold,
    input  logic       stop,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       busy,
    output logic       _scs,
    output logic       sck,
    output logic       sdo,
    input  logic       sdi
);

    localparam int MAX_AB  = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
    localparam int MAX_CNT = (MAX_AB > CS_IDLE) ? MAX_AB : CS_IDLE;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    // Phase counters are loaded with N-1 and count down to zero.
    localparam logic [CW-1:0] HP_LOAD    = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] IDLE_LOAD  = CW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_DESEL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          hold_q, hold_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          scs_q, scs_d;
    logic          sck_q, sck_d;
    logic          sdo_q, sdo_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        hold_d    = hold_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_d    = tx_data;
                    hold_d  = cs_hold;
                    cnt_d   = SETUP_LOAD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = HP_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    cnt_d   = HP_LOAD;
                    rx_d    = {rx_q[6:0], sdi};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_data_d = rx_q;
                        done_d    = 1'b1;
                        if (hold_q) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_DESEL;
                            cnt_d   = IDLE_LOAD;
                        end
                    end else begin
                        state_d = S_LOW;
                        cnt_d   = HP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                // A start that coincides with stop keeps the frame open.
                if (start) begin
                    tx_d    = tx_data;
                    hold_d  = cs_hold;
                    state_d = S_LOW;
                    cnt_d   = HP_LOAD;
                    bit_d   = 3'd0;
                end else if (stop) begin
                    state_d = S_DESEL;
                    cnt_d   = IDLE_LOAD;
                end
            end
            S_DESEL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are decoded from the next state so every output leaves a flop.
        scs_d  = !(state_d inside {S_SETUP, S_LOW, S_HIGH, S_HOLD});
        sck_d  = (state_d != S_LOW);
        sdo_d  = (state_d inside {S_LOW, S_HIGH}) ? tx_d[7] : 1'b0;
        busy_d = state_d inside {S_SETUP, S_LOW, S_HIGH, S_DESEL};
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the shift registers are reset too, so a reused host never shows stale bits.
        if (!_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            hold_q    <= 1'b0;
            rx_data_q <= 8'h00;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            scs_q     <= 1'b1;
            sck_q     <= 1'b1;
            sdo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            hold_q    <= hold_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            scs_q     <= scs_d;
            sck_q     <= sck_d;
            sdo_q     <= sdo_d;
        end
    end

    assign rx_data = rx_data_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign _scs    = scs_q;
    assign sck     = sck_q;
    assign sdo     = sdo_q;

endmodule

// File: tb/tb_osd_spi_host.sv
// Directed bench for osd_spi_host: a bus-level slave model checks MOSI bytes, MISO capture,
// frame timing, hold/stop handling and reset; a second instance exercises HALF_PERIOD=1.
module tb_osd_spi_host;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, cs_hold = 1'b0, stop = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       done, busy, scs_n, sck, sdo;
    logic       sdi = 1'b0;

    logic       start1 = 1'b0, cs_hold1 = 1'b0, stop1 = 1'b0, sdi1 = 1'b0;
    logic [7:0] tx_data1 = 8'h00;
    logic [7:0] rx_data1;
    logic       done1, busy1, scs1_n, sck1, sdo1;

    int checks = 0;
    int errors = 0;

    // Slave model state, owned by the monitor process below.
    logic [7:0]  slave_tx = 8'h00;
    logic [7:0]  slave_shift = 8'h00;
    logic [15:0] frame_bits = 16'h0000;
    int          frame_rises = 0;
    int          frame_falls = 0;
    logic        scs_prev = 1'b1;
    logic        sck_prev = 1'b1;

    always #5 clk = ~clk;

    osd_spi_host #(.HALF_PERIOD(2), .CS_SETUP(2), .CS_IDLE(2)) u_dut (
        .clk(clk), ._reset(reset_n), .start(start), .cs_hold(cs_hold), .stop(stop),
        .tx_data(tx_data), .rx_data(rx_data), .done(done), .busy(busy),
        ._scs(scs_n), .sck(sck), .sdo(sdo), .sdi(sdi)
    );

    osd_spi_host #(.HALF_PERIOD(1), .CS_SETUP(2), .CS_IDLE(2)) u_dut1 (
        .clk(clk), ._reset(reset_n), .start(start1), .cs_hold(cs_hold1), .stop(stop1),
        .tx_data(tx_data1), .rx_data(rx_data1), .done(done1), .busy(busy1),
        ._scs(scs1_n), .sck(sck1), .sdo(sdo1), .sdi(sdi1)
    );

    // Slave: shifts MISO out on falling SCK, captures MOSI on rising SCK, new frame on _scs fall.
    always @(negedge clk) begin
        if (scs_prev && !scs_n) begin
            frame_bits  = 16'h0000;
            frame_rises = 0;
            frame_falls = 0;
        end
        if (!scs_n && sck_prev && !sck) begin
            if (frame_falls % 8 == 0) slave_shift = slave_tx;
            sdi         = slave_shift[7];
            slave_shift = {slave_shift[6:0], 1'b0};
            frame_falls++;
        end
        if (!scs_n && !sck_prev && sck) begin
            frame_bits = {frame_bits[14:0], sdo};
            frame_rises++;
        end
        scs_prev = scs_n;
        sck_prev = sck;
    end

    // Called at a negedge following edge E0; start is sampled at E0+1, k counts edges after E0.
    task automatic go(input logic [7:0] tx, input logic hold, input logic stp,
                      output int done_at, output int fall_at, output int scs_hi_at,
                      output int busy_lo_at, output logic [7:0] rx_at_done);
        bit scs_was_low;
        scs_was_low = 1'b0;
        done_at = -1; fall_at = -1; scs_hi_at = -1; busy_lo_at = -1; rx_at_done = 8'h00;
        start = 1'b1; tx_data = tx; cs_hold = hold; stop = stp;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (fall_at < 0 && sck === 1'b0) fall_at = k;
            if (done === 1'b1 && done_at < 0) begin
                done_at    = k;
                rx_at_done = rx_data;
            end
            if (scs_n === 1'b0) scs_was_low = 1'b1;
            else if (scs_was_low && scs_hi_at < 0) scs_hi_at = k;
            if (done_at > 0 && busy === 1'b0 && busy_lo_at < 0) busy_lo_at = k;
            if (done_at > 0 && (hold || busy_lo_at > 0)) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({scs_n, sck, sdo, busy, done} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_pins: scs,sck,sdo,busy,done=%b required 11000", {scs_n, sck, sdo, busy, done});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        checks++;
        if ({scs1_n, sck1, sdo1, busy1, done1, rx_data1} !== {5'b11000, 8'h00}) begin
            errors++;
            $display("FAIL reset_dut1: got %b required 1100000000000", {scs1_n, sck1, sdo1, busy1, done1, rx_data1});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        int d, f, s, b;
        logic [7:0] r;
        slave_tx = 8'h3C;
        go(8'hA5, 1'b0, 1'b0, d, f, s, b, r);
        checks++;
        if (f !== 3) begin errors++; $display("FAIL single_first_fall: got %0d required 3", f); end
        checks++;
        if (d !== 35) begin errors++; $display("FAIL single_done_at: got %0d required 35", d); end
        checks++;
        if (r !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h required 3c", r); end
        checks++;
        if (s !== 35) begin errors++; $display("FAIL single_scs_high_at: got %0d required 35", s); end
        checks++;
        if (b !== 37) begin errors++; $display("FAIL single_busy_low_at: got %0d required 37", b); end
        checks++;
        if (frame_bits[7:0] !== 8'hA5) begin
            errors++; $display("FAIL single_slave_rx: got %h required a5", frame_bits[7:0]);
        end
        checks++;
        if (frame_rises !== 8 || frame_falls !== 8) begin
            errors++; $display("FAIL single_edges: rises %0d falls %0d required 8 8", frame_rises, frame_falls);
        end
    endtask

    task automatic test_two_byte_frame();
        int d, f, s, b;
        logic [7:0] r;
        slave_tx = 8'h5A;
        go(8'h81, 1'b1, 1'b0, d, f, s, b, r);
        checks++;
        if (d !== 35 || r !== 8'h5A) begin
            errors++; $display("FAIL frame_byte1: done_at %0d rx %h required 35 5a", d, r);
        end
        checks++;
        if (scs_n !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL frame_hold_state: scs %b busy %b required 0 0", scs_n, busy);
        end
        slave_tx = 8'hC3;
        go(8'h7E, 1'b0, 1'b0, d, f, s, b, r);
        checks++;
        if (f !== 1 || d !== 33) begin
            errors++; $display("FAIL frame_byte2_timing: fall %0d done %0d required 1 33", f, d);
        end
        checks++;
        if (r !== 8'hC3) begin errors++; $display("FAIL frame_byte2_rx: got %h required c3", r); end
        checks++;
        if (frame_bits !== 16'h817E || frame_rises !== 16) begin
            errors++; $display("FAIL frame_slave_bits: got %h (%0d bits) required 817e (16)", frame_bits, frame_rises);
        end
        checks++;
        if (s !== 33) begin errors++; $display("FAIL frame_scs_high_at: got %0d required 33", s); end
    endtask

    task automatic test_back_to_back_start();
        int ndone;
        bit seen;
        ndone = 0;
        seen  = 1'b0;
        slave_tx = 8'h96;
        start = 1'b1; tx_data = 8'h3C; cs_hold = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            tx_data = 8'hFF;
            if (done === 1'b1) begin ndone++; seen = 1'b1; end
            if (seen && busy === 1'b0) break;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d required 1", ndone); end
        checks++;
        if (frame_rises !== 8 || frame_falls !== 8) begin
            errors++; $display("FAIL b2b_edges: rises %0d falls %0d required 8 8", frame_rises, frame_falls);
        end
        checks++;
        if (frame_bits[7:0] !== 8'h3C || rx_data !== 8'h96) begin
            errors++; $display("FAIL b2b_data: slave %h host %h required 3c 96", frame_bits[7:0], rx_data);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int rises;
        bit prev, dseen;
        rises = 0;
        dseen = 1'b0;
        prev  = sck;
        slave_tx = 8'hF0;
        start = 1'b1; tx_data = 8'hA5; cs_hold = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!prev && sck) rises++;
            prev = sck;
            if (rises == 3) break;
        end
        checks++;
        if (rises !== 3) begin errors++; $display("FAIL rst_mid_reach: rises %0d required 3", rises); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({scs_n, sck, sdo, busy, done} !== 5'b11000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_pins: scs,sck,sdo,busy,done=%b rx %h required 11000 00", {scs_n, sck, sdo, busy, done}, rx_data);
        end
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dseen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) dseen = 1'b1;
        end
        checks++;
        if (dseen !== 1'b0 || scs_n !== 1'b1) begin
            errors++; $display("FAIL rst_mid_no_done: done seen %b scs %b required 0 1", dseen, scs_n);
        end
    endtask

    task automatic test_hold_stop();
        int d, f, s, b;
        logic [7:0] r;
        slave_tx = 8'h11;
        go(8'h24, 1'b1, 1'b0, d, f, s, b, r);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (scs_n !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL stop_cycle1: scs %b busy %b required 1 1", scs_n, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stop_cycle2: busy %b required 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || scs_n !== 1'b1) begin
            errors++; $display("FAIL stop_cycle3: busy %b scs %b required 0 1", busy, scs_n);
        end
    endtask

    task automatic test_start_with_stop();
        int d, f, s, b;
        logic [7:0] r;
        slave_tx = 8'h42;
        go(8'hE7, 1'b1, 1'b0, d, f, s, b, r);
        go(8'h55, 1'b0, 1'b1, d, f, s, b, r);
        checks++;
        if (f !== 1 || d !== 33) begin
            errors++; $display("FAIL start_stop_timing: fall %0d done %0d required 1 33", f, d);
        end
        checks++;
        if (frame_bits !== 16'hE755 || frame_rises !== 16) begin
            errors++; $display("FAIL start_stop_frame: got %h (%0d bits) required e755 (16)", frame_bits, frame_rises);
        end
    endtask

    task automatic hp1_byte(input logic miso, input logic [7:0] exp_rx);
        int bad, done_at;
        bad = 0;
        done_at = -1;
        sdi1 = miso;
        start1 = 1'b1; tx_data1 = 8'h69;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (k >= 3 && k <= 18 && sck1 !== ((k % 2) == 0)) bad++;
            if (done1 === 1'b1 && done_at < 0) done_at = k;
            if (done_at > 0 && busy1 === 1'b0) break;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hp1_sck_period: %0d off-pattern cycles required 0", bad); end
        checks++;
        if (done_at !== 19) begin errors++; $display("FAIL hp1_done_at: got %0d required 19", done_at); end
        checks++;
        if (rx_data1 !== exp_rx) begin errors++; $display("FAIL hp1_rx_data: got %h required %h", rx_data1, exp_rx); end
    endtask

    task automatic test_half_period_one();
        hp1_byte(1'b1, 8'hFF);
        hp1_byte(1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_byte_frame();
        test_back_to_back_start();
        test_reset_mid_transfer();
        test_hold_stop();
        test_start_with_stop();
        test_half_period_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_spi_host.md
Name: osd_spi_host

Overview:
- Single-byte SPI master: the host-side counterpart of the OSD SPI slave port.
- Generates chip select, SCK, MOSI and samples MISO. Mode: SCK idle high, data changed on falling SCK, sampled on rising SCK, MSB first.
- Byte-level start/done handshake to local logic.
- Optional chip-select hold lets a command byte be followed by data bytes in one frame.

Parameters:
- HALF_PERIOD, 4, clk cycles per SCK half period (>=1)
- CS_SETUP, 2, clk cycles from _scs falling to first SCK falling edge (>=1)
- CS_IDLE, 2, minimum clk cycles _scs stays high after a frame before the next start is accepted (>=1)

Ports:
- clk  input  1  system clock
- _reset  input  1  synchronous active-low reset
- start  input  1  begin byte transfer; accepted only when busy=0
- cs_hold  input  1  sampled with start; 1 = keep _scs low after this byte
- stop  input  1  in HOLD: end frame and deassert _scs
- tx_data  input  8  byte to send; captured when start is accepted
- rx_data  output  8  byte received from MISO
- done  output  1  one-cycle pulse; byte complete, rx_data valid
- busy  output  1  transfer or deselect in progress
- _scs  output  1  SPI chip select, active low
- sck  output  1  SPI clock, idle high
- sdo  output  1  MOSI
- sdi  input  1  MISO

Behaviour:
- Reset (_reset=0 at a clk edge):
  - Outputs: _scs=1, sck=1, sdo=0, busy=0, done=0, rx_data=0.
  - State goes to IDLE.
  - Applies mid-transfer: the frame is aborted immediately, no done pulse is issued.
- States: IDLE, SETUP, LOW, HIGH, HOLD, DESEL.
- IDLE (_scs=1, sck=1, busy=0):
  - On start: capture tx_data into tx shift register, latch cs_hold, go to SETUP.
- SETUP: _scs=0, sck=1, busy=1, for CS_SETUP cycles, then go to LOW.
- LOW, HALF_PERIOD cycles:
  - sck=0, sdo=tx_shift[7].
  - Entering LOW is the falling edge; sdo changes on that same clk edge.
- HIGH, HALF_PERIOD cycles:
  - sck=1.
  - On the clk edge entering HIGH, shift sdi into the rx shift register LSB (MSB received first).
  - On leaving HIGH: shift tx_shift left and increment the 3-bit bit counter.
  - Bit counter < 7 wrapped: go to LOW. After the 8th HIGH: go to completion.
- Completion (same edge as the exit from the 8th HIGH):
  - rx_data <= assembled byte, done=1 for exactly one cycle.
  - Latched cs_hold=1: go to HOLD.
  - Latched cs_hold=0: go to DESEL and set _scs=1 on that same edge.
- HOLD (_scs=0, sck=1, busy=0):
  - start: capture tx_data and cs_hold, go directly to LOW.
  - stop alone: go to DESEL.
  - start and stop together: start wins, stop ignored.
- DESEL: _scs=1, sck=1, busy=1, for CS_IDLE cycles, then IDLE.
- start while busy=1 is ignored; no queuing. stop outside HOLD is ignored.
- sdo=0 in every state other than LOW/HIGH.
- Latency:
  - Start accepted in IDLE at edge E0: first SCK fall at E0+1+CS_SETUP; done high during cycle E0+1+CS_SETUP+16*HALF_PERIOD.
  - Start accepted in HOLD at edge E0: first SCK fall at E0+1; done high during cycle E0+1+16*HALF_PERIOD.
- SCK duty cycle is exactly 50%. Exactly 8 falling and 8 rising SCK edges per byte.
- All outputs are registered, no glitches.
- Counter width is derived from max(HALF_PERIOD, CS_SETUP, CS_IDLE).

Test Plan:
- HALF_PERIOD=2, CS_SETUP=2, CS_IDLE=2; the bench slave model samples on rising SCK, shifts on falling SCK and returns 0x3C; start with tx_data=0xA5, cs_hold=0 at E0 -> slave captures 0xA5, rx_data=0x3C, done pulse at E0+35, _scs high from E0+35, busy low from E0+37.
- Two-byte frame: byte 1 0x81 with cs_hold=1, then start with 0x7E, cs_hold=0 in HOLD -> _scs stays low between bytes, second done at 1+32 cycles after its start, slave sees 0x81 then 0x7E in one frame.
- start pulsed every cycle while busy -> only the first start is accepted; exactly 8 SCK periods, one done.
- _reset asserted after the 3rd rising SCK -> next edge: _scs=1, sck=1, sdo=0, busy=0, rx_data=0, no done.
- In HOLD assert stop alone -> _scs high next edge, busy=1 for 2 cycles. Separately, assert start+stop together in HOLD -> new byte starts, _scs stays low.
- HALF_PERIOD=1 with MISO pattern 0xFF then 0x00 -> rx_data=0xFF then 0x00; SCK period is 2 clk cycles throughout.
